// File: rtl/enc_pkg.sv
// Shared encodings for the instruction encoder: op selects, RV32I fields and FSM states.
package enc_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_NOP  = 4'd7
    } encOpT;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] S_HOLD = 2'd2;
    localparam logic [STATE_W-1:0] S_DONE = 2'd3;

    // True when a 32-bit value survives sign-extension from 12 bits.
    function automatic logic immFits12(input logic [XLEN-1:0] imm);
        return (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
    endfunction

endpackage

// File: rtl/inst_encode_comb.sv
// Combinational RV32I field-to-word encoder with an illegal flag.
// ENC_RANGE_CHECK_EN: reject immediates outside the signed 12-bit range.
module inst_encode_comb
    import enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word_c,
    output logic        illegal_c
);

    always_comb begin
        word_c    = NOP_WORD;
        illegal_c = 1'b0;
        case (op)
            OP_ADD:  word_c = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_SUB:  word_c = {F7_ALT, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_AND:  word_c = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OP_OR:   word_c = {F7_BASE, rs2, rs1, F3_OR, rd, OPC_OP};
            OP_ADDI: word_c = {imm[11:0], rs1, F3_ADD, rd, OPC_OPIMM};
            OP_LW:   word_c = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
            OP_SW:   word_c = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
            OP_NOP:  word_c = NOP_WORD;
            default: illegal_c = 1'b1;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        // Immediate formats only: an unrepresentable value becomes a flagged NOP.
        if ((op == OP_ADDI || op == OP_LW || op == OP_SW) && !immFits12(imm)) begin
            word_c    = NOP_WORD;
            illegal_c = 1'b1;
        end
`endif
    end

`ifndef ENC_RANGE_CHECK_EN
    logic unusedImmHi;
    assign unusedImmHi = ^imm[31:12];
`endif

endmodule

// File: rtl/inst_encoder.sv
// Encodes field bundles into RV32I words and streams them into imem sequentially.
// ENC_RANGE_CHECK_EN (in inst_encode_comb) enables immediate range checking.
module inst_encoder
    import enc_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    input  logic          imem_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned SUM_W = AW + 2;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] nextState;
    logic [31:0]        encWord;
    logic               encIllegal;
    logic               lastPend;
    logic               startPend;
    logic               accept;
    logic               take;
    logic               finish;
    logic               restart;
    logic [SUM_W-1:0]   issued;

    inst_encode_comb u_encode (
        .op        (in_op),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .imm       (in_imm),
        .word_c    (encWord),
        .illegal_c (encIllegal)
    );

    // Handshake: a new bundle needs a free (or draining) output slot and remaining depth.
    always_comb begin
        accept   = imem_we & imem_ready;
        issued   = SUM_W'(count) + SUM_W'(imem_we);
        in_ready = (state == S_RUN) && (!imem_we || imem_ready) && !lastPend
                   && (issued < SUM_W'(DEPTH));
        take     = in_valid & in_ready;
        finish   = accept && (lastPend || (SUM_W'(count) + SUM_W'(1) == SUM_W'(DEPTH)));
        restart  = ((state == S_IDLE) || (state == S_DONE)) && (start || startPend);
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE: if (restart) nextState = S_RUN;
            S_RUN: begin
                if (finish)                       nextState = S_DONE;
                else if (imem_we && !imem_ready)  nextState = S_HOLD;
            end
            S_HOLD: begin
                if (finish)      nextState = S_DONE;
                else if (accept) nextState = S_RUN;
            end
            S_DONE: if (restart) nextState = S_RUN;
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nextState;
    end

    // Output register, address/count tracking and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= AW'(BASE_ADDR);
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            lastPend   <= 1'b0;
            startPend  <= 1'b0;
        end else begin
            busy <= (nextState == S_RUN) || (nextState == S_HOLD);
            if (restart) begin
                imem_we   <= 1'b0;
                imem_addr <= AW'(BASE_ADDR);
                done      <= 1'b0;
                err       <= 1'b0;
                count     <= '0;
                lastPend  <= 1'b0;
                startPend <= 1'b0;
            end else begin
                if (accept) begin
                    imem_we   <= 1'b0;
                    imem_addr <= imem_addr + AW'(1);
                    count     <= count + CW'(1);
                end
                if (take) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= encWord;
                    lastPend   <= in_last;
                    err        <= err | encIllegal;
                end
                // A start coinciding with completion is replayed once DONE is reached.
                if (finish) begin
                    done      <= 1'b1;
                    lastPend  <= 1'b0;
                    startPend <= start;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed sessions plus a randomized stream vs a field-level model.
module tb_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sStart;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  count;

    logic        sInReady;
    logic        sWe;
    logic [7:0]  sAddr;
    logic [31:0] sWdata;
    logic        sBusy;
    logic        sDone;
    logic        sErr;
    logic [8:0]  sCount;

    int          checks = 0;
    int          errors = 0;
    int          writeIdx = 0;
    int          smallWrites = 0;
    bit          expErr = 0;
    bit          randReady = 0;
    logic [31:0] expQ[$];
    logic [31:0] mem[256];
    logic [31:0] smallMem[256];
    logic [31:0] monW;
    bit          monBad;

    inst_encoder #(.AW(8), .DEPTH(256), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready), .busy(busy), .done(done), .err(err), .count(count)
    );

    inst_encoder #(.AW(8), .DEPTH(4), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(sStart), .in_valid(in_valid), .in_ready(sInReady),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .imem_we(sWe), .imem_addr(sAddr), .imem_wdata(sWdata),
        .imem_ready(imem_ready), .busy(sBusy), .done(sDone), .err(sErr), .count(sCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference word built from field values by positional arithmetic.
    function automatic logic [31:0] refWord(input int unsigned op, input int unsigned rd,
                                            input int unsigned rs1, input int unsigned rs2,
                                            input logic [31:0] imm, output bit bad);
        logic [31:0] i12;
        logic [31:0] regs;
        logic [31:0] w;
        i12  = imm & 32'h0000_0FFF;
        regs = 32'(rd) * 32'd128 + 32'(rs1) * 32'd32768 + 32'(rs2) * 32'd1048576;
        bad  = 1'b0;
        case (op)
            0: w = 32'h0000_0033 + regs;
            1: w = 32'h4000_0033 + regs;
            2: w = 32'h0000_0033 + 32'd7 * 32'd4096 + regs;
            3: w = 32'h0000_0033 + 32'd6 * 32'd4096 + regs;
            4: w = 32'h0000_0013 + 32'(rd) * 32'd128 + 32'(rs1) * 32'd32768 + i12 * 32'd1048576;
            5: w = 32'h0000_0003 + 32'd2 * 32'd4096 + 32'(rd) * 32'd128 + 32'(rs1) * 32'd32768
                   + i12 * 32'd1048576;
            6: w = 32'h0000_0023 + 32'd2 * 32'd4096 + (i12 % 32'd32) * 32'd128
                   + 32'(rs1) * 32'd32768 + 32'(rs2) * 32'd1048576 + (i12 / 32'd32) * 32'd33554432;
            7: w = 32'h0000_0013;
            default: begin
                w   = 32'h0000_0013;
                bad = 1'b1;
            end
        endcase
`ifdef ENC_RANGE_CHECK_EN
        if (op >= 4 && op <= 6 && !(($signed(imm) >= -2048) && ($signed(imm) <= 2047))) begin
            w   = 32'h0000_0013;
            bad = 1'b1;
        end
`endif
        return w;
    endfunction

    // Scoreboard: accepted bundles queue expected words; accepted writes must match in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we && imem_ready) begin
                check("wr_expected", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    monW = expQ.pop_front();
                    check("wr_data", imem_wdata, monW);
                    check("wr_addr", 32'(imem_addr), 32'(writeIdx));
                end
                mem[imem_addr] = imem_wdata;
                writeIdx++;
            end
            if (in_valid && in_ready) begin
                monW = refWord(32'(in_op), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm, monBad);
                expQ.push_back(monW);
                expErr = expErr | monBad;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && sWe && imem_ready) begin
            smallMem[sAddr] = sWdata;
            smallWrites++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (randReady) imem_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic doStart();
        start    = 1'b1;
        writeIdx = 0;
        expErr   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int unsigned op, input int unsigned rd, input int unsigned rs1,
                        input int unsigned rs2, input logic [31:0] imm, input bit last);
        in_op    = 4'(op);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = imm;
        in_last  = last;
        in_valid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic waitDone(input int maxCyc);
        int c = 0;
        while (!done && c < maxCyc) begin
            @(negedge clk);
            c++;
        end
        check("done_reached", 32'(done), 32'd1);
        check("exp_drained", 32'(expQ.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit          b;
        logic [31:0] rimm;
        rst_n = 1'b0; start = 1'b0; sStart = 1'b0; in_valid = 1'b0; in_op = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0; imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // ADDI / ADD / SUB session
        doStart();
        send(4, 1, 0, 0, 32'd5, 0);
        send(0, 3, 1, 2, 32'd0, 0);
        send(1, 4, 3, 1, 32'd0, 1);
        waitDone(50);
        check("s1_w0", mem[0], 32'h0050_0093);
        check("s1_w1", mem[1], 32'h0020_81B3);
        check("s1_w2", mem[2], 32'h4011_8233);
        check("s1_count", 32'(count), 32'd3);
        check("s1_err", 32'(err), 32'd0);
        check("s1_busy", 32'(busy), 32'd0);

        // LW / SW session
        doStart();
        send(5, 5, 1, 0, 32'd8, 0);
        send(6, 0, 2, 5, 32'd12, 1);
        waitDone(50);
        check("s2_w0", mem[0], 32'h0080_A283);
        check("s2_w1", mem[1], 32'h0051_2623);
        check("s2_count", 32'(count), 32'd2);

        // Backpressure on the first write
        doStart();
        imem_ready = 1'b0;
        send(4, 2, 0, 0, 32'd7, 0);
        in_op = 4'd0; in_rd = 5'd6; in_rs1 = 5'd2; in_rs2 = 5'd3; in_imm = '0;
        in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_we", 32'(imem_we), 32'd1);
            check("hold_addr", 32'(imem_addr), 32'd0);
            check("hold_wdata", imem_wdata, 32'h0070_0113);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
        send(0, 6, 2, 3, 32'd0, 1);
        waitDone(50);
        check("hold_count", 32'(count), 32'd2);
        check("hold_w1", mem[1], refWord(0, 6, 2, 3, 32'd0, b));

        // Illegal op writes NOP, err sticks, session continues
        doStart();
        send(9, 1, 2, 3, 32'd0, 0);
        send(3, 7, 1, 2, 32'd0, 1);
        waitDone(50);
        check("ill_w0", mem[0], 32'h0000_0013);
        check("ill_w1", mem[1], 32'h0020_E3B3);
        check("ill_err", 32'(err), 32'd1);
        check("ill_count", 32'(count), 32'd2);

        // Out-of-range immediate
        doStart();
        send(4, 1, 0, 0, 32'd4096, 1);
        waitDone(50);
`ifdef ENC_RANGE_CHECK_EN
        check("rng_w0", mem[0], 32'h0000_0013);
        check("rng_err", 32'(err), 32'd1);
`else
        check("rng_w0", mem[0], 32'h0000_0093);
        check("rng_err", 32'(err), 32'd0);
`endif

        // Randomized stream with random backpressure
        doStart();
        randReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rimm = $urandom;
            if ($urandom_range(0, 2) != 0) rimm = 32'($urandom_range(0, 4095)) - 32'd2048;
            send($urandom_range(0, 11), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), rimm, i == 39);
        end
        waitDone(400);
        randReady = 1'b0;
        @(posedge clk); #2;
        imem_ready = 1'b1;
        check("rnd_count", 32'(count), 32'd40);
        check("rnd_err", 32'(err), 32'(expErr));

        // Depth limit on the DEPTH=4 instance: six bundles offered, four written
        @(posedge clk); #1;
        sStart = 1'b1;
        smallWrites = 0;
        @(posedge clk); #1;
        sStart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_op = 4'd4; in_rd = 5'(i + 1); in_rs1 = 5'd0; in_rs2 = 5'd0;
            in_imm = 32'(i * 3); in_last = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("dep_writes", 32'(smallWrites), 32'd4);
        for (int i = 0; i < 4; i++)
            check("dep_word", smallMem[i], refWord(4, 32'(i + 1), 0, 0, 32'(i * 3), b));
        check("dep_done", 32'(sDone), 32'd1);
        check("dep_count", 32'(sCount), 32'd4);
        check("dep_busy", 32'(sBusy), 32'd0);
        check("dep_in_ready", 32'(sInReady), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Asynchronous reset while a write is held
        doStart();
        imem_ready = 1'b0;
        send(4, 1, 0, 0, 32'd5, 0);
        @(negedge clk);
        @(negedge clk);
        check("rh_we_before", 32'(imem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rh_we", 32'(imem_we), 32'd0);
        check("rh_busy", 32'(busy), 32'd0);
        check("rh_in_ready", 32'(in_ready), 32'd0);
        check("rh_addr", 32'(imem_addr), 32'd0);
        check("rh_wdata", imem_wdata, 32'd0);
        check("rh_count", 32'(count), 32'd0);
        expQ.delete();
        writeIdx = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        check("rh_idle_busy", 32'(busy), 32'd0);
        check("rh_idle_ready", 32'(in_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Instruction encoder and program loader, the write-side counterpart of the instruction decoder.
- Accepts structured instruction fields (op, rd, rs1, rs2, imm) over a valid/ready stream and encodes each into a 32-bit RV32I word.
- Writes the words sequentially into instruction memory through a backpressured write port.
- Used by the boot/test loader to fill imem before the core leaves reset.

Parameters:
- AW, 8, instruction-memory word-address width.
- DEPTH, 256, number of writable words; must be <= 2**AW.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session at BASE_ADDR.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_op  in  4  op select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 NOP; 8-15 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  first source register.
- in_rs2  in  5  second source register.
- in_imm  in  32  signed immediate.
- in_last  in  1  marks the final bundle of the session.
- imem_we  out  1  write request, held until accepted.
- imem_addr  out  AW  word address.
- imem_wdata  out  32  encoded instruction.
- imem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  session active.
- done  out  1  sticky; session complete.
- err  out  1  sticky; an illegal op (or, with ENC_RANGE_CHECK_EN, an out-of-range immediate) was seen this session.
- count  out  AW+1  words written this session.

Behaviour:
Reset values:
- All outputs 0; imem_addr = BASE_ADDR; FSM in IDLE.

FSM states:
- IDLE: in_ready=0, busy=0. On start, clear count/done/err, set imem_addr=BASE_ADDR, go to RUN.
- RUN: busy=1, in_ready=1 when the output register is empty or is being accepted this cycle (imem_we & imem_ready).
  - On in_valid & in_ready, the encoded word is registered; imem_we rises the next cycle (latency 1).
  - Back-to-back bundles sustain one write per cycle while imem_ready=1.
- HOLD: imem_we=1 with stable addr/wdata until imem_ready. Entered when the output register is full and not accepted.
- DONE: busy=0, done=1, in_ready=0, imem_we=0. Entered after the write carrying in_last is accepted, or after the DEPTH-th write is accepted. A new start restarts the session from RUN.

Addressing and counting:
- imem_addr increments by 1 per accepted write. count increments by 1 per accepted write.
- Reaching DEPTH writes forces DONE. Any bundle offered afterwards is not accepted (in_ready=0).
- No wrap-around inside a session.

Encoding (standard RV32I):
- ADD/SUB/AND/OR: opcode 0110011; funct3 000/000/111/110; funct7 0000000, except SUB 0100000.
- ADDI: 0010011, funct3 000, imm[11:0].
- LW: 0000011, funct3 010.
- SW: 0100011, funct3 010, imm split [11:5] and [4:0].
- NOP: 0x00000013.
- Unused register fields of a format are ignored.
- Illegal op: writes NOP and sets err. Encoding continues.

Simultaneous and corner events:
- start while in RUN or HOLD: ignored.
- start in the same cycle as DONE entry: DONE wins; start is honoured the following cycle.
- in_last accepted while an earlier word is still in HOLD: the last word is written after it, then DONE.
- rst_n low mid-write: imem_we drops immediately (asynchronous), session lost.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined: in_imm must satisfy -2048 <= in_imm <= 2047 for ADDI/LW/SW. Otherwise the word is replaced by NOP and err is set.
- Undefined: in_imm is silently truncated to its low 12 bits, and err reflects illegal ops only.

Decomposition:
- Shared package enc_pkg: op enum (OP_ADD..OP_NOP), opcode/funct3/funct7 constants, NOP_WORD constant, FSM state enum.
- One natural sub-module: inst_encode_comb. Pure combinational; fields to 32-bit word plus illegal flag.
- inst_encoder owns the FSM, output register, address counter and handshake.

Test Plan:
- Reset, start, then ADDI rd=1 rs1=0 imm=5; ADD rd=3 rs1=1 rs2=2; SUB rd=4 rs1=3 rs2=1 (last) -> writes 0x00500093@0, 0x002081B3@1, 0x40118233@2; done=1, count=3, err=0.
- LW rd=5 rs1=1 imm=8 then SW rs2=5 rs1=2 imm=12 (last) -> 0x0080A283, 0x00512623.
- imem_ready held low 3 cycles on the first write -> imem_we/addr/wdata stable, in_ready=0 while HOLD; no word lost or duplicated; count=N at done.
- in_op=9 -> NOP 0x00000013 written, err=1 sticky, session continues.
- ADDI imm=4096 -> with ENC_RANGE_CHECK_EN: NOP written, err=1; without it: 0x00000093 written (imm truncated to 0), err=0.
- DEPTH=4, six bundles, no in_last -> four writes at addr 0-3, DONE after the fourth, in_ready=0 thereafter. rst_n pulsed low mid-HOLD -> all outputs 0 at once, FSM in IDLE.
